// File: rtl/ascii_loader.sv
// ascii_loader: paced ASCII text injector from the HPS ioctl download stream
// (index 0) into the UK101 serial receive path.
// Bytes are buffered in a small FIFO, back-pressured with ioctl_wait, and
// line endings are normalised. Characters are then presented one at a time,
// with an idle gap after each one and a longer gap after CR.
// Optional build macro: ASCII_LOADER_UPPERCASE_EN folds a-z to A-Z after
// the bit-7 strip.
module ascii_loader #(
  parameter int FIFO_DEPTH = 16,
  parameter int CHAR_GAP   = 24000,
  parameter int LINE_GAP   = 480000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       enable,
  input  logic       ioctl_download,
  input  logic [7:0] ioctl_index,
  input  logic       ioctl_wr,
  input  logic [7:0] ioctl_dout,
  output logic       ioctl_wait,
  output logic [7:0] char_data,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       busy,
  output logic       overflow
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam int GAP_MAX = (CHAR_GAP > LINE_GAP) ? CHAR_GAP : LINE_GAP;
  localparam int GW      = (GAP_MAX < 2) ? 1 : $clog2(GAP_MAX + 1);

  localparam logic [CW-1:0] FULL_LVL   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] WAIT_LVL   = CW'(FIFO_DEPTH - 2);
  localparam logic [GW-1:0] CHAR_GAP_W = GW'(CHAR_GAP);
  localparam logic [GW-1:0] LINE_GAP_W = GW'(LINE_GAP);

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_NUL = 8'h00;
  localparam logic [7:0] ASCII_SUB = 8'h1A;

  typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_GAP} state_t;

  // Filter one raw byte. Result bit 8 is the pass flag; bits 7:0 are the
  // character to present.
  function automatic logic [8:0] filter_byte(input logic [7:0] raw,
                                             input logic       prev_cr);
    logic [7:0] c;
    logic       pass;
    c    = raw & 8'h7F;
`ifdef ASCII_LOADER_UPPERCASE_EN
    if (c >= 8'h61 && c <= 8'h7A) c = c - 8'h20;
`endif
    pass = 1'b1;
    if (c == ASCII_LF) begin
      // LF that completes a CR/LF pair vanishes; a bare LF ends a line.
      if (prev_cr) pass = 1'b0;
      else         c    = ASCII_CR;
    end else if (c == ASCII_NUL || c == ASCII_SUB) begin
      pass = 1'b0;
    end
    return {pass, c};
  endfunction

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          wr_attempt;

  state_t        state;
  state_t        state_nxt;
  logic [GW-1:0] gap_cnt;
  logic [GW-1:0] gap_sel;
  logic          gap_start;
  logic          char_load;
  logic          prev_cr;
  logic          dl_q;
  logic          dl_rise;
  logic [7:0]    head_raw;
  logic [8:0]    filt;
  logic          head_is_cr;

  assign full       = (count == FULL_LVL);
  assign empty      = (count == '0);
  assign wr_attempt = ioctl_wr && ioctl_download && enable && (ioctl_index == 8'd0);
  assign push       = wr_attempt && !full;
  assign dl_rise    = ioctl_download && !dl_q;
  assign head_raw   = fifo_mem[rd_ptr];
  assign head_is_cr = ((head_raw & 8'h7F) == ASCII_CR);
  assign filt       = filter_byte(head_raw, prev_cr);

  assign char_valid = (state == S_PRESENT);
  assign busy       = ioctl_download | !empty | (state != S_IDLE);

  // Next-state, pop decision and gap selection for the output FSM.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    char_load = 1'b0;
    gap_start = 1'b0;
    gap_sel   = '0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (filt[8]) begin
            char_load = 1'b1;
            state_nxt = S_PRESENT;
          end
        end
      end
      S_PRESENT: begin
        if (char_ready) begin
          gap_sel = (char_data == ASCII_CR) ? LINE_GAP_W : CHAR_GAP_W;
          if (gap_sel == '0) begin
            state_nxt = S_IDLE;
          end else begin
            gap_start = 1'b1;
            state_nxt = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt <= GW'(1)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (!enable) begin
      state_nxt = S_IDLE;
      pop       = 1'b0;
      char_load = 1'b0;
      gap_start = 1'b0;
    end
  end

  // Occupancy after this cycle's push/pop; flushing forces it to zero.
  always_comb begin
    count_nxt = count + CW'(push) - CW'(pop);
    if (!enable) count_nxt = '0;
  end

  // FIFO storage; data only, never reset.
  always_ff @(posedge clk_sys) begin
    if (push) fifo_mem[wr_ptr] <= ioctl_dout;
  end

  // FIFO pointers and occupancy; disable flushes the buffer.
  always_ff @(posedge clk_sys) begin
    if (reset || !enable) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
    end
  end

  // Registered stall request, leaving room for one write already in flight.
  always_ff @(posedge clk_sys) begin
    if (reset) ioctl_wait <= 1'b0;
    else       ioctl_wait <= enable && (count_nxt >= WAIT_LVL);
  end

  // Download edge tracker, sticky overflow and previous-CR flag.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_q     <= 1'b0;
      overflow <= 1'b0;
      prev_cr  <= 1'b0;
    end else begin
      dl_q <= ioctl_download;
      if (wr_attempt && full) overflow <= 1'b1;
      else if (dl_rise)       overflow <= 1'b0;
      if (dl_rise)            prev_cr  <= 1'b0;
      else if (char_load)     prev_cr  <= head_is_cr;
    end
  end

  // Output FSM state register and presented character.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= S_IDLE;
      char_data <= 8'h00;
    end else begin
      state <= state_nxt;
      if (char_load) char_data <= filt[7:0];
    end
  end

  // Inter-character gap counter.
  always_ff @(posedge clk_sys) begin
    if (reset || !enable)    gap_cnt <= '0;
    else if (gap_start)      gap_cnt <= gap_sel;
    else if (state == S_GAP) gap_cnt <= gap_cnt - GW'(1);
  end

endmodule
